// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles little-endian 32-bit words
// from a valid/ready byte stream and writes them to consecutive word addresses.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [31:0]       mem_wd,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_asm;
    logic [ADDR_W:0]   r_len;
    logic [7:0]        r_checksum;
    logic              r_err;
    logic [ADDR_W-1:0] r_mem_wa;
    logic [31:0]       r_mem_wd;

    logic              w_accept;
    logic              w_len_ok;
    logic              w_last;
    logic              w_word_end;

    assign w_accept   = (r_state == RECV) && byte_valid;
    assign w_len_ok   = (load_len != '0) && (load_len <= LEN_MAX);
    assign w_last     = ({1'b0, r_word_idx} == (r_len - LEN_ONE));
    assign w_word_end = w_accept && (r_byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (load_start && w_len_ok) begin
                    w_next = RECV;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                if (abort) begin
                    w_next = IDLE;
                end else if (w_word_end) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                // The write still happens in this cycle even when aborted.
                mem_we = 1'b1;
                if (abort) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = RECV;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_len      <= '0;
            r_checksum <= '0;
            r_err      <= 1'b0;
            r_mem_wa   <= '0;
            r_mem_wd   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_start) begin
                        if (w_len_ok) begin
                            r_word_idx <= '0;
                            r_byte_cnt <= '0;
                            r_checksum <= '0;
                            r_err      <= 1'b0;
                            r_len      <= load_len;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (w_accept) begin
                        r_checksum <= r_checksum ^ byte_in;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0:    r_asm[7:0]   <= byte_in;
                            2'd1:    r_asm[15:8]  <= byte_in;
                            2'd2:    r_asm[23:16] <= byte_in;
                            default: r_asm        <= r_asm;
                        endcase
                    end
                    // Address/data are latched only for a word that will be written.
                    if (w_word_end && !abort) begin
                        r_mem_wa <= r_word_idx;
                        r_mem_wd <= {byte_in, r_asm};
                    end
                    if (abort) begin
                        r_err <= 1'b1;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        r_err <= 1'b1;
                    end else if (!w_last) begin
                        r_word_idx <= r_word_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_wa   = r_mem_wa;
    assign mem_wd   = r_mem_wd;
    assign cpu_hold = busy;
    assign err      = r_err;
    assign checksum = r_checksum;

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the processor's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each completed word is written to consecutive instruction-memory addresses starting at 0, and the CPU is held during the load. It sits between the host/debug byte source and the instruction memory write port.

## Interface
- ADDR_W, 6, instruction-memory word-address width
- DEPTH, 64, maximum loadable words (must be ≤ 2^ADDR_W)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_start  input  1  one-cycle request to begin a load; sampled only in IDLE
- load_len  input  ADDR_W+1  number of words to load, sampled with load_start; valid range 1..DEPTH
- abort  input  1  cancels an in-progress load
- byte_in  input  8  stream data byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction-memory write enable, one cycle per word
- mem_wa  output  ADDR_W  write word address
- mem_wd  output  32  write data
- busy  output  1  load in progress
- cpu_hold  output  1  holds the processor in reset while loading
- done  output  1  one-cycle pulse when a load completes
- err  output  1  sticky error flag
- checksum  output  8  XOR of all bytes accepted in the current or most recent load

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- **IDLE:** byte_ready=0, busy=0, cpu_hold=0.
  - load_start=1 with load_len in 1..DEPTH: go to RECV. Clear word_idx, byte_cnt, checksum and err.
  - load_start=1 with load_len=0 or load_len>DEPTH: set err=1 and stay in IDLE. checksum is unchanged.
- **RECV:** byte_ready=1. A byte is accepted when byte_valid && byte_ready.
  - The accepted byte goes to lane byte_cnt of the assembly register (byte 0 → [7:0], byte 3 → [31:24]).
  - checksum ^= byte_in; byte_cnt increments (2-bit, wraps).
  - On acceptance of the 4th byte (byte_cnt==3): go to WRITE.
- **WRITE:** byte_ready=0 and mem_we=1 for exactly this cycle, with mem_wa=word_idx and mem_wd=assembled word.
  - If word_idx==load_len-1: go to DONE.
  - Otherwise word_idx increments and the FSM returns to RECV.
- **DONE:** done=1 for one cycle, then go to IDLE.
- busy and cpu_hold are 1 in RECV, WRITE and DONE.
- **abort** in RECV or WRITE: go to IDLE next cycle and set err=1.
  - A WRITE that coincides with abort still performs its write.
  - Words already written stay in memory; done is not pulsed.
  - abort in IDLE or DONE is ignored.
- load_start outside IDLE is ignored.
- mem_wa/mem_wd hold their last values when mem_we=0. The memory must ignore them while we=0.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state IDLE;
  - byte_ready, mem_we, busy, cpu_hold, done and err all 0;
  - mem_wa=0, mem_wd=0, checksum=0;
  - internal counters 0.
- Reset mid-load abandons the load immediately; no further writes occur.
- Load start: load_start in cycle T → busy, cpu_hold and byte_ready are all 1 in cycle T+1.
- Byte-to-write latency: the 4th byte of a word accepted in cycle C → mem_we=1 in cycle C+1.
- Throughput: with byte_valid held high, each word takes 5 cycles (4 accept + 1 write).
- Full load: N words take 5N cycles from first byte to last write. The done pulse follows in the next cycle, and busy=0 the cycle after that.
- Stalls: byte_valid low in RECV stalls indefinitely with no timeout and no state change.
- Error flag: err changes only on a start attempt or on abort, and clears on the next accepted load_start.

## Test plan
- **Two-word load.** load_len=2; bytes 07 50 86 00 23 91 85 01 with byte_valid held high.
  - Expect mem_we at wa=0 with wd=0x00865007, then at wa=1 with wd=0x01859123.
  - done pulses one cycle after the second write; checksum=0xE7; err=0.
- **Stalled stream.** Same load with byte_valid deasserted for 3 cycles between every byte.
  - Expect identical writes and checksum.
  - byte_ready stays 1 throughout RECV; no write occurs before the 4th byte.
- **Bad length.** load_len=0 and, separately, load_len=65 with DEPTH=64.
  - Expect err=1, busy=0, no mem_we.
  - A following valid load_start with load_len=1 clears err.
- **Abort.** Abort after 6 bytes of a 3-word load.
  - Exactly one write (wa=0); next cycle state is IDLE with busy=0, cpu_hold=0, err=1; done never pulses.
- **Full depth and reset.** Load 64 words of pattern 0xA5A5_0000+i.
  - Expect wa values 0..63 in order, then done.
  - Then assert rst_n=0 mid-way through a second load: all outputs are 0 asynchronously and no further mem_we occurs.
